// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the instruction cache /
// memory stage and a byte-wide unified RAM with one-cycle read latency.
// Data requests win over instruction fetches. Each transfer moves 1, 2 or 4
// little-endian bytes, one per cycle, and completion is a one-cycle pulse.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   inst_needed     fetch request level; inst_addr_i is its address
//   inst_mem        fetched instruction; inst_addr_mem is its address
//   inst_available  one-cycle fetch completion pulse
//   flush           abort an in-progress fetch
//   data_req        load/store request level; data_we 1 = store
//   data_addr       byte address; data_len 00 byte, 01 half, 1x word
//   data_wdata      store data; data_rdata zero-extended load data
//   data_done       one-cycle load/store completion pulse
//   mem_din         RAM read byte (valid the cycle after its address)
//   mem_dout, mem_a, mem_wr   RAM write byte, byte address, write enable
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_needed,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_mem,
  output logic [31:0] inst_addr_mem,
  output logic        inst_available,
  input  logic        flush,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [31:0] base;
  logic [2:0]  nbytes;
  logic [2:0]  step;
  logic        is_inst;
  logic [31:0] wdata;
  logic [23:0] rd_buf;
  logic [31:0] rd_word;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   len_to_n = 3'd1;
      2'b01:   len_to_n = 3'd2;
      default: len_to_n = 3'd4;
    endcase
  endfunction

  // The last byte of a read is still on mem_din at the finishing edge, so the
  // result is assembled from the captured bytes plus the live RAM byte.
  always_comb begin
    rd_word = {8'h00, rd_buf};
    case (nbytes)
      3'd1:    rd_word = {24'h000000, mem_din};
      3'd2:    rd_word = {16'h0000, mem_din, rd_buf[7:0]};
      default: rd_word = {mem_din, rd_buf};
    endcase
  end

  // step counts edges since the accepting edge: in RD it both selects the
  // next address (step < n) and the byte arriving from RAM (step - 2).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      base           <= '0;
      nbytes         <= '0;
      step           <= '0;
      is_inst        <= 1'b0;
      wdata          <= '0;
      rd_buf         <= '0;
      inst_mem       <= '0;
      inst_addr_mem  <= '0;
      inst_available <= 1'b0;
      data_rdata     <= '0;
      data_done      <= 1'b0;
      mem_dout       <= '0;
      mem_a          <= '0;
      mem_wr         <= 1'b0;
    end else begin
      inst_available <= 1'b0;
      data_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            base    <= data_addr;
            nbytes  <= len_to_n(data_len);
            is_inst <= 1'b0;
            wdata   <= data_wdata;
            step    <= 3'd1;
            rd_buf  <= '0;
            mem_a   <= data_addr;
            if (data_we) begin
              mem_wr   <= 1'b1;
              mem_dout <= data_wdata[7:0];
              state    <= WR;
            end else begin
              state <= RD;
            end
          end else if (inst_needed) begin
            base    <= inst_addr_i;
            nbytes  <= 3'd4;
            is_inst <= 1'b1;
            step    <= 3'd1;
            rd_buf  <= '0;
            mem_a   <= inst_addr_i;
            state   <= RD;
          end
        end

        RD: begin
          if (is_inst && flush) begin
            state <= IDLE;
          end else begin
            if (step < nbytes) begin
              mem_a <= base + {29'd0, step};
            end
            if (step == nbytes + 3'd1) begin
              if (is_inst) begin
                inst_mem       <= rd_word;
                inst_addr_mem  <= base;
                inst_available <= 1'b1;
              end else begin
                data_rdata <= rd_word;
                data_done  <= 1'b1;
              end
              state <= DONE;
            end else begin
              case (step)
                3'd2:    rd_buf[7:0]   <= mem_din;
                3'd3:    rd_buf[15:8]  <= mem_din;
                3'd4:    rd_buf[23:16] <= mem_din;
                default: ;
              endcase
              step <= step + 3'd1;
            end
          end
        end

        WR: begin
          if (step < nbytes) begin
            mem_a <= base + {29'd0, step};
            case (step[1:0])
              2'd1:    mem_dout <= wdata[15:8];
              2'd2:    mem_dout <= wdata[23:16];
              default: mem_dout <= wdata[31:24];
            endcase
            step <= step + 3'd1;
          end else begin
            mem_wr    <= 1'b0;
            data_done <= 1'b1;
            state     <= DONE;
          end
        end

        // Requests are ignored here so a level request still held high
        // during its done pulse is not served a second time.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
